// File: rtl/control_acceso_pkg.sv
// -----------------------------------------------------------------------------
// control_acceso_pkg
// Shared definitions for the parking-lot access controller.
//   lane_state_t : progress of a car through a two-photocell lane
//   CMD_*        : command codes on the counter's Z1/Z0 pair
// -----------------------------------------------------------------------------
package control_acceso_pkg;

    // L_A: only the first cell is blocked; L_AB: both; L_B: only the second.
    typedef enum logic [1:0] {
        L_IDLE = 2'b00,
        L_A    = 2'b01,
        L_AB   = 2'b10,
        L_B    = 2'b11
    } lane_state_t;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

endpackage

// File: rtl/control_acceso_if.sv
// -----------------------------------------------------------------------------
// control_acceso_if
// Bundles the sensor, button and counter-side signals of the access controller.
//   btn_ent                    entry request button (asynchronous)
//   s_ent_a / s_ent_b          entry photocells, outer / inner
//   s_sal_a / s_sal_b          exit photocells, inner / outer
//   lleno                      counter full flag
//   Z1, Z0                     counter command
//   barrera_ent                entry barrier open
//   listo                      controller operational
// slave  : the controller's view
// master : the surrounding environment's view
// -----------------------------------------------------------------------------
interface control_acceso_if;
    logic btn_ent;
    logic s_ent_a;
    logic s_ent_b;
    logic s_sal_a;
    logic s_sal_b;
    logic lleno;
    logic Z1;
    logic Z0;
    logic barrera_ent;
    logic listo;

    modport slave (
        input  btn_ent, s_ent_a, s_ent_b, s_sal_a, s_sal_b, lleno,
        output Z1, Z0, barrera_ent, listo
    );

    modport master (
        output btn_ent, s_ent_a, s_ent_b, s_sal_a, s_sal_b, lleno,
        input  Z1, Z0, barrera_ent, listo
    );
endinterface

// File: rtl/contador.sv
// -----------------------------------------------------------------------------
// contador
// Reset-less 3-bit parking occupancy counter driven by a Z1/Z0 command pair.
//   clk     clock
//   Z1, Z0  00 hold, 01 increment (saturates at 7), 10 decrement (saturates at 0)
//   cuenta  current occupancy
//   lleno   occupancy == 7
// -----------------------------------------------------------------------------
module contador (
    input  logic       clk,
    input  logic       Z1,
    input  logic       Z0,
    output logic [2:0] cuenta,
    output logic       lleno
);

    // No reset: the access controller clears this counter after every reset
    // by issuing a burst of decrements.
    always_ff @(posedge clk) begin
        case ({Z1, Z0})
            2'b01: if (cuenta != 3'd7) cuenta <= cuenta + 3'd1;
            2'b10: if (cuenta != 3'd0) cuenta <= cuenta - 3'd1;
            default: ;
        endcase
    end

    assign lleno = (cuenta == 3'd7);

endmodule

// File: rtl/control_acceso_carril_fsm.sv
// -----------------------------------------------------------------------------
// carril_fsm
// Tracks one car crossing a lane with two photocells (a = first crossed,
// b = second). A full a -> ab -> b -> none crossing yields a one-cycle commit;
// backing out of the first cell yields a one-cycle abort.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          allows leaving L_IDLE (later states progress regardless)
//   a, b        synchronized photocell states
//   commit      car fully crossed (combinational, one cycle)
//   abort       car backed out from L_A (combinational, one cycle)
//   idle        lane is in L_IDLE
// -----------------------------------------------------------------------------
module carril_fsm
    import control_acceso_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic commit,
    output logic abort,
    output logic idle
);

    lane_state_t state;
    lane_state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= L_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Unlisted input combinations keep the current state, so sensor
    // glitches that skip a step are simply ignored.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        abort      = 1'b0;
        case (state)
            L_IDLE: begin
                if (en && a && !b) state_next = L_A;
            end
            L_A: begin
                if (a && b) begin
                    state_next = L_AB;
                end else if (!a && !b) begin
                    state_next = L_IDLE;
                    abort      = 1'b1;
                end
            end
            L_AB: begin
                if (!a && b)      state_next = L_B;
                else if (a && !b) state_next = L_A;
            end
            L_B: begin
                if (!a && !b) begin
                    state_next = L_IDLE;
                    commit     = 1'b1;
                end else if (a && b) begin
                    state_next = L_AB;
                end
            end
            default: state_next = L_IDLE;
        endcase
    end

    assign idle = (state == L_IDLE);

endmodule

// File: rtl/control_acceso.sv
// -----------------------------------------------------------------------------
// control_acceso
// Parking-lot access controller: watches the entry and exit lanes, runs the
// entry barrier, arbitrates increment/decrement commands onto the occupancy
// counter and clears that counter after every reset.
//   clk, rst_n  clock, asynchronous active-low reset
//   acc         control_acceso_if.slave: sensors, button, lleno in;
//               Z1/Z0, barrera_ent, listo out
// Parameters
//   INIT_CYCLES decrements issued after reset (>= 7 to reach zero)
//   TIMEOUT     idle cycles before an unused open barrier closes
//   SYNC_STAGES flip-flops on every asynchronous input
// -----------------------------------------------------------------------------
module control_acceso
    import control_acceso_pkg::*;
#(
    parameter int INIT_CYCLES = 8,
    parameter int TIMEOUT     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    control_acceso_if.slave acc
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 2);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(INIT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    logic [4:0] raw_in;
    logic [4:0] sync_ff [SYNC_STAGES];
    logic       btn_s, ent_a, ent_b, sal_a, sal_b;
    logic       btn_prev, btn_rise;

    logic [INIT_W-1:0] init_cnt;
    logic              listo, init_dec;

    logic ent_commit, ent_abort, ent_idle;
    logic sal_commit, sal_abort, sal_idle;

    logic             barrera;
    logic [TMR_W-1:0] timer;

    logic       inc_pend, dec_pend, issued_q, serve;
    logic [1:0] cmd, z;

    // All five asynchronous inputs share one shift chain.
    assign raw_in = {acc.btn_ent, acc.s_ent_a, acc.s_ent_b, acc.s_sal_a, acc.s_sal_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
        end else begin
            sync_ff[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
        end
    end

    assign {btn_s, ent_a, ent_b, sal_a, sal_b} = sync_ff[SYNC_STAGES-1];

    // The button acts on its synchronized rising edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_prev <= 1'b0;
        else        btn_prev <= btn_s;
    end

    assign btn_rise = btn_s && !btn_prev;

    // init_cnt runs 0 -> INIT_CYCLES+1 once after reset. Values 1..INIT_CYCLES
    // drive the clearing decrements; the final value marks the controller ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (init_cnt != INIT_DONE) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign listo    = (init_cnt == INIT_DONE);
    assign init_dec = (init_cnt != '0) && !listo;

    // The entry lane may only start a crossing while the barrier is open.
    carril_fsm u_ent (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (listo && barrera),
        .a      (ent_a),
        .b      (ent_b),
        .commit (ent_commit),
        .abort  (ent_abort),
        .idle   (ent_idle)
    );

    carril_fsm u_sal (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (listo),
        .a      (sal_a),
        .b      (sal_b),
        .commit (sal_commit),
        .abort  (sal_abort),
        .idle   (sal_idle)
    );

    // Barrier: opens on a request when there is room and no entry still being
    // counted; closes when the car finishes or backs out, or after TIMEOUT idle
    // cycles. Extra button presses while open are ignored, so they never
    // extend the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            barrera <= 1'b0;
            timer   <= '0;
        end else if (barrera) begin
            if (ent_commit || ent_abort) begin
                barrera <= 1'b0;
                timer   <= '0;
            end else if (ent_idle) begin
                if (timer == TMR_LAST) begin
                    barrera <= 1'b0;
                    timer   <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end else if (btn_rise && listo && !acc.lleno && !inc_pend && ent_idle) begin
            barrera <= 1'b1;
            timer   <= '0;
        end
    end

    // Arbiter choice from the pending flags. A command is never issued in the
    // cycle right after another one, so a pending request waits one cycle.
    // Simultaneous inc and dec cancel out and are retired without a command.
    always_comb begin
        cmd   = CMD_HOLD;
        serve = 1'b0;
        if (listo && !issued_q) begin
            if (inc_pend && dec_pend) begin
                serve = 1'b1;
            end else if (inc_pend) begin
                cmd   = CMD_INC;
                serve = 1'b1;
            end else if (dec_pend) begin
                cmd   = CMD_DEC;
                serve = 1'b1;
            end
        end
    end

    // Commits land in the pending flags; servicing clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_pend <= 1'b0;
            dec_pend <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            inc_pend <= (inc_pend && !serve) || ent_commit;
            dec_pend <= (dec_pend && !serve) || sal_commit;
            issued_q <= (cmd != CMD_HOLD);
        end
    end

    assign z = init_dec ? CMD_DEC : cmd;

    assign acc.Z1          = z[1];
    assign acc.Z0          = z[0];
    assign acc.barrera_ent = barrera;
    assign acc.listo       = listo;

endmodule

// File: tb/tb_control_acceso.sv
// -----------------------------------------------------------------------------
// tb_control_acceso
// Self-checking bench for control_acceso driving a contador instance.
// A table of lane transactions runs first from a known empty lot, followed by
// hand-written corner sequences and random transactions scored against a
// simple occupancy model.
// -----------------------------------------------------------------------------
module tb_control_acceso;
    import control_acceso_pkg::*;

    localparam logic [1:0] SN  = 2'b00;
    localparam logic [1:0] SA  = 2'b10;
    localparam logic [1:0] SAB = 2'b11;
    localparam logic [1:0] SB  = 2'b01;

    typedef struct {
        logic        press;
        logic        lane;
        logic [11:0] steps;
        int          nsteps;
        logic        exp_open;
        int          exp_inc;
        int          exp_dec;
        int          exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_acceso_if acc();

    logic       preload = 1'b1;
    logic [1:0] tb_z = 2'b00;
    logic [2:0] cuenta;
    logic       cz1, cz0;

    assign cz1 = preload ? tb_z[1] : acc.Z1;
    assign cz0 = preload ? tb_z[0] : acc.Z0;

    control_acceso #(.INIT_CYCLES(8), .TIMEOUT(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (acc.slave)
    );

    contador u_cnt (
        .clk    (clk),
        .Z1     (cz1),
        .Z0     (cz0),
        .cuenta (cuenta),
        .lleno  (acc.lleno)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    int         inc_seen = 0;
    int         dec_seen = 0;
    int         b2b_cnt = 0;
    int         illegal_cnt = 0;
    logic [1:0] prev_cmd = 2'b00;
    logic [1:0] mon_cmd;
    bit         rec_on = 1'b0;
    logic [1:0] trace [$];

    int   model_occ;
    vec_t tbl [10];
    vec_t rv;
    int   i0, d0, c0, idx, high_cnt, npre;
    logic [1:0] t0, t1, t2;

    // Observes committed commands once the controller is operational.
    always @(negedge clk) begin
        if (rst_n && acc.listo) begin
            mon_cmd = {acc.Z1, acc.Z0};
            if (mon_cmd == CMD_INC) inc_seen++;
            if (mon_cmd == CMD_DEC) dec_seen++;
            if (mon_cmd == 2'b11) illegal_cnt++;
            if (mon_cmd != CMD_HOLD && prev_cmd != CMD_HOLD) b2b_cnt++;
            prev_cmd = mon_cmd;
            if (rec_on) trace.push_back(mon_cmd);
        end else begin
            prev_cmd = CMD_HOLD;
        end
    end

    function automatic logic [11:0] mk(input logic [1:0] s0, s1, s2, s3, s4, s5);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic setLane(input logic lane, input logic [1:0] ab);
        if (lane == 1'b0) {acc.s_ent_a, acc.s_ent_b} = ab;
        else              {acc.s_sal_a, acc.s_sal_b} = ab;
    endtask

    task automatic pressBtn();
        acc.btn_ent = 1'b1;
        tick(3);
        acc.btn_ent = 1'b0;
        tick(3);
    endtask

    task automatic checkReset(input string tag);
        checkOutput($sformatf("%s_z", tag), int'({acc.Z1, acc.Z0}), 0);
        checkOutput($sformatf("%s_barrera", tag), int'(acc.barrera_ent), 0);
        checkOutput($sformatf("%s_listo", tag), int'(acc.listo), 0);
    endtask

    // Called at a negedge right after rst_n is released.
    task automatic checkInit(input string tag);
        int decs = 0;
        int listo_at = -1;
        int z_at = -1;
        int cnt_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (listo_at < 0) begin
                if (acc.listo) begin
                    listo_at = i;
                    z_at     = int'({acc.Z1, acc.Z0});
                    cnt_at   = int'(cuenta);
                end else if ({acc.Z1, acc.Z0} == CMD_DEC) begin
                    decs++;
                end
            end
        end
        checkOutput($sformatf("%s_dec_cycles", tag), decs, 8);
        checkOutput($sformatf("%s_listo_cycle", tag), listo_at, 8);
        checkOutput($sformatf("%s_z_at_listo", tag), z_at, 0);
        checkOutput($sformatf("%s_counter", tag), cnt_at, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int inc0 = inc_seen;
        int dec0 = dec_seen;
        int opened;
        if (v.press) pressBtn();
        opened = int'(acc.barrera_ent);
        for (int s = 0; s < v.nsteps; s++) begin
            setLane(v.lane, v.steps[2*s +: 2]);
            tick(4);
        end
        setLane(v.lane, SN);
        tick(8);
        checkOutput($sformatf("%s_open", tag), opened, int'(v.exp_open));
        checkOutput($sformatf("%s_inc", tag), inc_seen - inc0, v.exp_inc);
        checkOutput($sformatf("%s_dec", tag), dec_seen - dec0, v.exp_dec);
        checkOutput($sformatf("%s_count", tag), int'(cuenta), v.exp_cnt);
        checkOutput($sformatf("%s_closed", tag), int'(acc.barrera_ent), 0);
    endtask

    // Occupancy model: an entry counts only if the lot had room when the
    // button was pressed; an exit always issues a decrement, floor at zero.
    task automatic makeRec(input int kind, output vec_t v);
        v = '{1'b0, 1'b0, 12'd0, 0, 1'b0, 0, 0, 0};
        case (kind)
            0: begin
                v.press = 1'b1; v.lane = 1'b0; v.nsteps = 4;
                v.steps = mk(SA, SAB, SB, SN, SN, SN);
                v.exp_open = (model_occ < 7);
                if (v.exp_open) begin
                    v.exp_inc = 1;
                    model_occ = model_occ + 1;
                end
            end
            1: begin
                v.press = 1'b1; v.lane = 1'b0; v.nsteps = 2;
                v.steps = mk(SA, SN, SN, SN, SN, SN);
                v.exp_open = (model_occ < 7);
            end
            2: begin
                v.lane = 1'b1; v.nsteps = 4;
                v.steps = mk(SA, SAB, SB, SN, SN, SN);
                v.exp_dec = 1;
                model_occ = (model_occ > 0) ? model_occ - 1 : 0;
            end
            default: begin
                v.lane = 1'b1; v.nsteps = 4;
                v.steps = mk(SA, SAB, SA, SN, SN, SN);
            end
        endcase
        v.exp_cnt = model_occ;
    endtask

    initial begin
        acc.btn_ent = 1'b0;
        acc.s_ent_a = 1'b0;
        acc.s_ent_b = 1'b0;
        acc.s_sal_a = 1'b0;
        acc.s_sal_b = 1'b0;

        // Transactions from an empty lot: {press, lane, steps, n, open, inc, dec, count}
        tbl[0] = '{1'b1, 1'b0, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b1, 1, 0, 1};
        tbl[1] = '{1'b1, 1'b0, mk(SA, SN, SN, SN, SN, SN), 2, 1'b1, 0, 0, 1};
        tbl[2] = '{1'b1, 1'b0, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b1, 1, 0, 2};
        tbl[3] = '{1'b0, 1'b0, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b0, 0, 0, 2};
        tbl[4] = '{1'b0, 1'b1, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b0, 0, 1, 1};
        tbl[5] = '{1'b0, 1'b1, mk(SA, SAB, SA, SN, SN, SN), 4, 1'b0, 0, 0, 1};
        tbl[6] = '{1'b0, 1'b1, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b0, 0, 1, 0};
        tbl[7] = '{1'b0, 1'b1, mk(SA, SAB, SB, SN, SN, SN), 4, 1'b0, 0, 1, 0};
        tbl[8] = '{1'b1, 1'b0, mk(SA, SAB, SA, SAB, SB, SN), 6, 1'b1, 1, 0, 1};
        tbl[9] = '{1'b1, 1'b0, mk(SA, SAB, SB, SAB, SB, SN), 6, 1'b1, 1, 0, 2};

        // Leave the reset-less counter at a random nonzero value.
        npre = $urandom_range(1, 7);
        tb_z = CMD_INC;
        tick(npre);
        tb_z = CMD_HOLD;
        preload = 1'b0;
        tick(1);
        $display("[TB] counter preloaded to %0d", cuenta);
        checkReset("reset");

        rst_n = 1'b1;
        checkInit("init");
        tick(2);

        for (int i = 0; i < 10; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));
        model_occ = 2;

        // Entry and exit commit in the same cycle cancel out.
        i0 = inc_seen; d0 = dec_seen; c0 = int'(cuenta);
        pressBtn();
        checkOutput("same_open", int'(acc.barrera_ent), 1);
        for (int s = 0; s < 4; s++) begin
            setLane(1'b0, mk(SA, SAB, SB, SN, SN, SN)[2*s +: 2]);
            setLane(1'b1, mk(SA, SAB, SB, SN, SN, SN)[2*s +: 2]);
            tick(4);
        end
        tick(8);
        checkOutput("same_inc", inc_seen - i0, 0);
        checkOutput("same_dec", dec_seen - d0, 0);
        checkOutput("same_count", int'(cuenta), c0);

        // Exit commit one cycle after entry: 01, gap, 10.
        trace.delete();
        rec_on = 1'b1;
        pressBtn();
        for (int s = 0; s < 4; s++) begin
            setLane(1'b0, mk(SA, SAB, SB, SN, SN, SN)[2*s +: 2]);
            tick(1);
            setLane(1'b1, mk(SA, SAB, SB, SN, SN, SN)[2*s +: 2]);
            tick(3);
        end
        tick(10);
        rec_on = 1'b0;
        idx = -1;
        for (int i = 0; i < trace.size(); i++) if (idx < 0 && trace[i] != CMD_HOLD) idx = i;
        t0 = 2'b11; t1 = 2'b11; t2 = 2'b11;
        if (idx >= 0 && idx + 2 < trace.size()) begin
            t0 = trace[idx]; t1 = trace[idx+1]; t2 = trace[idx+2];
        end
        checkOutput("offset_first", int'(t0), int'(CMD_INC));
        checkOutput("offset_gap", int'(t1), int'(CMD_HOLD));
        checkOutput("offset_second", int'(t2), int'(CMD_DEC));
        checkOutput("offset_count", int'(cuenta), c0);

        // Random transactions against the occupancy model.
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 99);
            makeRec((r < 40) ? 0 : (r < 55) ? 1 : (r < 90) ? 2 : 3, rv);
            applyStimulus(rv, $sformatf("rnd%0d", n));
        end

        // Fill the lot, then a request must not open the barrier.
        for (int n = 0; n < 8 && model_occ < 7; n++) begin
            makeRec(0, rv);
            applyStimulus(rv, $sformatf("fill%0d", n));
        end
        checkOutput("full_lleno", int'(acc.lleno), 1);
        makeRec(0, rv);
        applyStimulus(rv, "full_entry");
        makeRec(2, rv);
        applyStimulus(rv, "full_exit");

        // Unused barrier closes after 16 cycles; a second press does not extend it.
        high_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            acc.btn_ent = (i < 2) || (i == 6) || (i == 7);
            @(negedge clk);
            if (acc.barrera_ent) high_cnt++;
        end
        checkOutput("timeout_open_cycles", high_cnt, 16);

        // Reset while a car sits between both entry cells.
        pressBtn();
        setLane(1'b0, SA);
        tick(4);
        setLane(1'b0, SAB);
        tick(4);
        checkOutput("midrst_open_before", int'(acc.barrera_ent), 1);
        #2 rst_n = 1'b0;
        #1 checkReset("midrst");
        setLane(1'b0, SN);
        tick(3);
        rst_n = 1'b1;
        checkInit("reinit");

        checkOutput("no_back_to_back", b2b_cnt, 0);
        checkOutput("no_cmd_11", illegal_cnt, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
